// File: rtl/fir_pkg.sv
// Shared definitions for the FIR core sequencer.
// Holds the sequencer state type and the default data / tap-count widths.
package fir_pkg;

    localparam int P_DATA_WIDTH    = 32;
    localparam int P_TAP_NUM_WIDTH = 10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_WAIT = 3'd2,
        S_MAC  = 3'd3,
        S_OUT  = 3'd4,
        S_DONE = 3'd5
    } fir_state_e;

endpackage

// File: rtl/fir_mac.sv
// Multiply-accumulate datapath for the FIR core.
// Ports:
//   clk_i, rst_ni  clock / async active-low reset
//   clr_i          zero the accumulator (start of a new output sample)
//   en_i           add tap_i*data_i into the accumulator this cycle
//   tap_i, data_i  signed operands
//   acc_o          accumulator, wraps modulo 2^W
module fir_mac
    import fir_pkg::*;
#(
    parameter int W = P_DATA_WIDTH
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] tap_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] acc_o
);

    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;
    logic [W-1:0] prod_lo;

    // Low W bits of a two's-complement product do not depend on operand
    // signedness, so a W-bit multiply gives the signed result directly.
    assign prod_lo = tap_i * data_i;

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + prod_lo;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/fir_core_sequencer.sv
// FIR core sequencer: clears the data shifter, then for every input sample
// walks the taps through the MAC and presents the result on the output stream.
// Ports:
//   axis_clk, axis_rst_n        clock / async active-low reset
//   ap_start/ap_idle/ap_done    block-level control handshake
//   tap_num                     tap count, sampled when a job is accepted
//   core_clr_wait/core_data_EN  shifter clear phase / shifter wants a sample
//   core_tap_EN/core_tap_A      tap RAM + shifter read enable and index
//   tap_Do/data_Do              read data, valid one cycle after core_tap_A
//   ss_tvalid/ss_tlast          input stream qualifiers
//   sm_*                        output AXI-Stream
//
// state | meaning
// IDLE  | waiting for ap_start with non-zero tap_num
// CLR   | clearing shifter, tap_num cycles
// WAIT  | requesting next input sample
// MAC   | issuing taps 0..tap_num-1, plus one drain cycle
// OUT   | holding result until sm_tready
// DONE  | one-cycle ap_done pulse
module fir_core_sequencer
    import fir_pkg::*;
#(
    parameter int pDATA_WIDTH   = P_DATA_WIDTH,
    parameter int TAP_NUM_WIDTH = P_TAP_NUM_WIDTH
) (
    input  logic                     axis_clk,
    input  logic                     axis_rst_n,
    input  logic                     ap_start,
    output logic                     ap_idle,
    output logic                     ap_done,
    input  logic [TAP_NUM_WIDTH-1:0] tap_num,
    output logic                     core_clr_wait,
    output logic                     core_data_EN,
    output logic                     core_tap_EN,
    output logic [TAP_NUM_WIDTH-1:0] core_tap_A,
    input  logic [pDATA_WIDTH-1:0]   tap_Do,
    input  logic [pDATA_WIDTH-1:0]   data_Do,
    input  logic                     ss_tvalid,
    input  logic                     ss_tlast,
    output logic                     sm_tvalid,
    output logic [pDATA_WIDTH-1:0]   sm_tdata,
    output logic                     sm_tlast,
    input  logic                     sm_tready
);

    localparam logic [TAP_NUM_WIDTH-1:0] ONE = TAP_NUM_WIDTH'(1);

    fir_state_e               state_q, state_d;
    logic [TAP_NUM_WIDTH-1:0] tap_num_q, tap_num_d;
    logic [TAP_NUM_WIDTH-1:0] cnt_q, cnt_d;
    logic                     last_q, last_d;
    logic                     issue_q, issue_d;
    logic                     acc_clr;
    logic [pDATA_WIDTH-1:0]   acc;

    always_comb begin
        state_d       = state_q;
        tap_num_d     = tap_num_q;
        cnt_d         = cnt_q;
        last_d        = last_q;
        issue_d       = 1'b0;
        acc_clr       = 1'b0;
        ap_idle       = 1'b0;
        ap_done       = 1'b0;
        core_clr_wait = 1'b0;
        core_data_EN  = 1'b0;
        core_tap_EN   = 1'b0;
        core_tap_A    = '0;
        sm_tvalid     = 1'b0;
        sm_tlast      = 1'b0;
        case (state_q)
            S_IDLE: begin
                ap_idle = 1'b1;
                if (ap_start && (tap_num != '0)) begin
                    tap_num_d = tap_num;
                    cnt_d     = '0;
                    state_d   = S_CLR;
                end
            end
            S_CLR: begin
                core_clr_wait = 1'b1;
                if (cnt_q == tap_num_q - ONE) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_WAIT: begin
                core_data_EN = 1'b1;
                if (ss_tvalid) begin
                    last_d  = ss_tlast;
                    acc_clr = 1'b1;
                    cnt_d   = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                // cnt_q == tap_num_q is the drain cycle: the last read
                // returns now and is accumulated at the end of this cycle.
                if (cnt_q != tap_num_q) begin
                    core_tap_EN = 1'b1;
                    core_tap_A  = cnt_q;
                    issue_d     = 1'b1;
                    cnt_d       = cnt_q + ONE;
                end else begin
                    cnt_d   = '0;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                sm_tvalid = 1'b1;
                sm_tlast  = last_q;
                if (sm_tready) begin
                    state_d = last_q ? S_DONE : S_WAIT;
                end
            end
            S_DONE: begin
                ap_done = 1'b1;
                last_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q   <= S_IDLE;
            tap_num_q <= '0;
            cnt_q     <= '0;
            last_q    <= 1'b0;
            issue_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tap_num_q <= tap_num_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            issue_q   <= issue_d;
        end
    end

    // issue_q lines up the accumulate with read data arriving one cycle
    // after the address.
    fir_mac #(
        .W(pDATA_WIDTH)
    ) u_mac (
        .clk_i (axis_clk),
        .rst_ni(axis_rst_n),
        .clr_i (acc_clr),
        .en_i  (issue_q),
        .tap_i (tap_Do),
        .data_i(data_Do),
        .acc_o (acc)
    );

    assign sm_tdata = acc;

endmodule
